// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message feeder.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_PAD  = 3'd1,
    S_ZERO = 3'd2,
    S_LEN  = 3'd3,
    S_FULL = 3'd4
  } state_t;

  localparam logic [7:0] PAD_BYTE      = 8'h80;
  localparam logic [5:0] LEN_POS       = 6'd56;
  localparam logic [5:0] ZERO_END      = 6'd55;
  localparam logic [5:0] LAST_PTR      = 6'd63;
  localparam int         BLK_BYTES     = 64;
  localparam int         WORDS_PER_BLK = 16;

  // Byte idx (0 = most significant) of the 64-bit big-endian length field.
  function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = len[63:56];
      3'd1:    b = len[55:48];
      3'd2:    b = len[47:40];
      3'd3:    b = len[39:32];
      3'd4:    b = len[31:24];
      3'd5:    b = len[23:16];
      3'd6:    b = len[15:8];
      3'd7:    b = len[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// 16x32 block buffer: big-endian byte write port, bulk clear, async word read.
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_we,
  input  logic [5:0]  i_ptr,
  input  logic [7:0]  i_data,
  input  logic        i_clear,
  input  logic [3:0]  i_rd_idx,
  output logic [31:0] o_rd_word
);

  logic [31:0] r_mem [WORDS_PER_BLK];
  logic [4:0]  w_lsb;

  // Byte 0 of a word lands in bits 31:24, byte 3 in bits 7:0.
  assign w_lsb     = {~i_ptr[1:0], 3'b000};
  assign o_rd_word = r_mem[i_rd_idx];

  // Storage: clear has priority over a byte write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WORDS_PER_BLK; i++) r_mem[i] <= 32'h0;
    end else if (i_clear) begin
      for (int i = 0; i < WORDS_PER_BLK; i++) r_mem[i] <= 32'h0;
    end else if (i_we) begin
      r_mem[i_ptr[5:2]][w_lsb +: 8] <= i_data;
    end
  end

endmodule

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: byte stream in, padded 512-bit blocks out as M_next words.
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        blk_valid,
  output logic        blk_last,
  input  logic        blk_done,
  input  logic [5:0]  round_idx,
  output logic [31:0] M_next
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_byte_ptr;
  logic [LEN_W-1:0] r_bit_len;
  logic             r_len_pend;   // length did not fit: next block is zero fill + length
  logic             r_pad_pend;   // message ended on byte 63: next block starts with 0x80
  logic             r_blk_last;
  logic             w_we;
  logic [7:0]       w_wdata;
  logic             w_clear;
  logic [5:0]       w_zero_end;
  logic [63:0]      w_len64;
  logic [31:0]      w_rd_word;

  assign w_len64    = 64'(r_bit_len);
  assign w_zero_end = r_len_pend ? LAST_PTR : ZERO_END;
  assign in_ready   = (r_state == S_LOAD);
  assign blk_valid  = (r_state == S_FULL);
  assign blk_last   = r_blk_last;
  assign M_next     = (blk_valid && (round_idx < 6'd16)) ? w_rd_word : 32'h0;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_LOAD;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD: begin
        if (in_valid) begin
          if (r_byte_ptr == LAST_PTR) w_state_nxt = S_FULL;
          else if (in_last)           w_state_nxt = S_PAD;
          else                        w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_PAD: begin
        if (r_byte_ptr == LAST_PTR)      w_state_nxt = S_FULL;
        else if (r_byte_ptr == ZERO_END) w_state_nxt = S_LEN;
        else                             w_state_nxt = S_ZERO;
      end
      S_ZERO: begin
        if (r_byte_ptr == w_zero_end) w_state_nxt = r_len_pend ? S_FULL : S_LEN;
        else                          w_state_nxt = S_ZERO;
      end
      S_LEN: begin
        if (r_byte_ptr == LAST_PTR) w_state_nxt = S_FULL;
        else                        w_state_nxt = S_LEN;
      end
      S_FULL: begin
        if (blk_done) begin
          if (r_pad_pend)      w_state_nxt = S_PAD;
          else if (r_len_pend) w_state_nxt = S_ZERO;
          else                 w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_FULL;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Buffer write controls per state.
  always_comb begin
    w_we    = 1'b0;
    w_wdata = 8'h00;
    w_clear = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_we    = in_valid;
        w_wdata = in_data;
      end
      S_PAD: begin
        w_we    = 1'b1;
        w_wdata = PAD_BYTE;
      end
      S_ZERO: begin
        w_we    = 1'b1;
        w_wdata = 8'h00;
      end
      S_LEN: begin
        w_we    = 1'b1;
        w_wdata = len_byte(w_len64, r_byte_ptr[2:0]);
      end
      S_FULL: begin
        w_clear = blk_done;
      end
      default: begin
        w_we    = 1'b0;
        w_wdata = 8'h00;
        w_clear = 1'b0;
      end
    endcase
  end

  // Byte pointer, running bit length and block flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_ptr <= 6'd0;
      r_bit_len  <= '0;
      r_len_pend <= 1'b0;
      r_pad_pend <= 1'b0;
      r_blk_last <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_byte_ptr <= r_byte_ptr + 6'd1;
            r_bit_len  <= r_bit_len + LEN_W'(8);
            if (r_byte_ptr == LAST_PTR) r_pad_pend <= in_last;
          end
        end
        S_PAD: begin
          r_byte_ptr <= r_byte_ptr + 6'd1;
          if (r_byte_ptr >= LEN_POS) r_len_pend <= 1'b1;
        end
        S_ZERO: begin
          r_byte_ptr <= r_byte_ptr + 6'd1;
        end
        S_LEN: begin
          r_byte_ptr <= r_byte_ptr + 6'd1;
          if (r_byte_ptr == LAST_PTR) r_blk_last <= 1'b1;
        end
        S_FULL: begin
          if (blk_done) begin
            r_byte_ptr <= 6'd0;
            r_len_pend <= 1'b0;
            r_pad_pend <= 1'b0;
            r_blk_last <= 1'b0;
            if (r_blk_last) r_bit_len <= '0;
          end
        end
        default: r_byte_ptr <= 6'd0;
      endcase
    end
  end

  sha256_blk_buf u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_we      (w_we),
    .i_ptr     (r_byte_ptr),
    .i_data    (w_wdata),
    .i_clear   (w_clear),
    .i_rd_idx  (round_idx[3:0]),
    .o_rd_word (w_rd_word)
  );

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Self-checking bench for sha256_msg_feeder: table of padded-block vectors plus corner sequences.
module tb_sha256_msg_feeder;

  logic        clk;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        blk_valid;
  logic        blk_last;
  logic        blk_done;
  logic [5:0]  round_idx;
  logic [31:0] M_next;

  int n_checks;
  int n_errors;

  // kind: 0 = "abc", 1 = all 0x00, 2 = byte k has value k
  typedef struct {
    int                    len;
    int                    kind;
    int                    nblk;
    logic [1:0][15:0][31:0] w;
    logic [1:0]            last;
  } vec_t;

  vec_t vecs [4];

  sha256_msg_feeder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .blk_done  (blk_done),
    .round_idx (round_idx),
    .M_next    (M_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] msg_byte(input int kind, input int k);
    logic [7:0] b;
    if (kind == 0)      b = 8'h61 + 8'(k);
    else if (kind == 1) b = 8'h00;
    else                b = 8'(k);
    return b;
  endfunction

  task automatic send(input int kind, input int len, input bit with_last);
    for (int k = 0; k < len; k++) begin
      int wcnt = 0;
      while (!in_ready && wcnt < 300) begin
        tick();
        wcnt++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
      end
      in_data  = msg_byte(kind, k);
      in_valid = 1'b1;
      in_last  = with_last && (k == len - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_full();
    int cnt = 0;
    while (!blk_valid && cnt < 300) begin
      tick();
      cnt++;
    end
    chk("blk_valid_wait", 32'(blk_valid), 32'd1);
  endtask

  task automatic release_blk();
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    chk("blk_valid_after_done", 32'(blk_valid), 32'd0);
  endtask

  task automatic check_block(input int v, input int b);
    chk($sformatf("v%0d_b%0d_last", v, b), 32'(blk_last), 32'(vecs[v].last[b]));
    chk($sformatf("v%0d_b%0d_in_ready", v, b), 32'(in_ready), 32'd0);
    for (int i = 0; i < 16; i++) begin
      round_idx = 6'(i);
      #1;
      chk($sformatf("v%0d_b%0d_W%0d", v, b, i), M_next, vecs[v].w[b][i]);
    end
    round_idx = 6'd0;
  endtask

  task automatic run_vec(input int v);
    send(vecs[v].kind, vecs[v].len, 1'b1);
    for (int b = 0; b < vecs[v].nblk; b++) begin
      wait_full();
      check_block(v, b);
      release_blk();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_done  = 1'b0;
    round_idx = 6'd0;

    for (int v = 0; v < 4; v++) begin
      vecs[v].w    = '0;
      vecs[v].last = 2'b00;
    end
    // "abc"
    vecs[0].len = 3;  vecs[0].kind = 0; vecs[0].nblk = 1;
    vecs[0].w[0][0] = 32'h61626380; vecs[0].w[0][15] = 32'h00000018; vecs[0].last[0] = 1'b1;
    // 55 zero bytes
    vecs[1].len = 55; vecs[1].kind = 1; vecs[1].nblk = 1;
    vecs[1].w[0][13] = 32'h00000080; vecs[1].w[0][15] = 32'h000001B8; vecs[1].last[0] = 1'b1;
    // 56 zero bytes: length spills to a second block
    vecs[2].len = 56; vecs[2].kind = 1; vecs[2].nblk = 2;
    vecs[2].w[0][14] = 32'h80000000; vecs[2].last[0] = 1'b0;
    vecs[2].w[1][15] = 32'h000001C0; vecs[2].last[1] = 1'b1;
    // 64 incrementing bytes, last on byte 63
    vecs[3].len = 64; vecs[3].kind = 2; vecs[3].nblk = 2;
    for (int i = 0; i < 16; i++) begin
      vecs[3].w[0][i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    end
    vecs[3].last[0] = 1'b0;
    vecs[3].w[1][0] = 32'h80000000; vecs[3].w[1][15] = 32'h00000200; vecs[3].last[1] = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_blk_valid", 32'(blk_valid), 32'd0);
    chk("rst_blk_last", 32'(blk_last), 32'd0);
    chk("rst_M_next", M_next, 32'h0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 4; v++) run_vec(v);

    // Hold the block for 100 cycles without blk_done
    send(0, 3, 1'b1);
    wait_full();
    for (int c = 0; c < 100; c++) begin
      tick();
      if ((c % 10) == 9) begin
        round_idx = 6'(c / 10);
        #1;
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_blk_valid", 32'(blk_valid), 32'd1);
        chk($sformatf("hold_W%0d", c / 10), M_next, vecs[0].w[0][c / 10]);
      end
    end
    round_idx = 6'd15;
    #1;
    chk("hold_W15", M_next, 32'h00000018);
    for (int r = 16; r < 64; r++) begin
      round_idx = 6'(r);
      #1;
      chk($sformatf("ridx%0d_zero", r), M_next, 32'h0);
    end
    round_idx = 6'd0;
    tick();
    release_blk();

    // Reset after 20 loaded bytes, then "abc" must match the first vector
    send(2, 20, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_blk_valid", 32'(blk_valid), 32'd0);
    chk("midrst_blk_last", 32'(blk_last), 32'd0);
    chk("midrst_M_next", M_next, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
